spart_tx: RTL and testbench

Serial transmit stage of the SPART: consumes the byte and strobe that the bus interface produces on a processor write to I/O address 0, and shifts the byte out on the TX pin as an 8N1 frame. It also holds the 16-bit baud divisor written through addresses 2 and 3 and reports transmit-buffer-ready (`tbr`) back to the bus interface's status read. It has a one-byte holding register in front of the shift register, so the processor can queue one byte while another is on the wire.

---
 rtl/spart_pkg.sv | 27 ++
 rtl/spart_tx_if.sv | 25 ++
 rtl/spart_baud_gen.sv | 46 ++++
 rtl/spart_tx.sv | 172 +++++++++++++++++
 tb/tb_spart_tx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// Shared SPART definitions: data/divisor widths, reset divisor, TX FSM states.
// Optional feature macro: SPART_TX_PARITY_EN adds the PARITY state (even parity).
package spart_pkg;

  localparam int unsigned DIV_W     = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  // 9600 baud at 50 MHz: bit period is DEFAULT_DIV+1 clocks
  localparam logic [DIV_W-1:0] DEFAULT_DIV = 16'd5207;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SPART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  // Even parity over a data byte
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/spart_tx_if.sv
// Bus-side signal bundle of the SPART transmitter: write strobes, data byte,
// transmit-buffer-ready status and the serial TX pin.
interface spart_tx_if;
  import spart_pkg::*;

  logic              transmit_write_en;
  logic [DATA_W-1:0] write_line;
  logic              baud_write_en;
  logic              baud_write_location;
  logic              tbr;
  logic              txd;

  // Bus interface side
  modport master (
    output transmit_write_en, write_line, baud_write_en, baud_write_location,
    input  tbr, txd
  );

  // Transmitter side
  modport slave (
    input  transmit_write_en, write_line, baud_write_en, baud_write_location,
    output tbr, txd
  );

endinterface

// File: rtl/spart_baud_gen.sv
// Baud generator: byte-writable 16-bit divisor and a down-counter that marks
// the last cycle of each bit. A bit lasts divisor+1 clocks; a divisor change
// only takes effect at the next reload.
module spart_baud_gen
  import spart_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_baud_we,
  input  logic              i_baud_loc,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_run,
  input  logic              i_reload,
  output logic              o_bit_end_c
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;

  // Divisor register, one byte lane per write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DEFAULT_DIV;
    end else if (i_baud_we) begin
      if (i_baud_loc) begin
        r_div[DIV_W-1:DATA_W] <= i_wdata;
      end else begin
        r_div[DATA_W-1:0] <= i_wdata;
      end
    end
  end

  // Bit-period down-counter; reload wins over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= r_div;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_bit_end_c = i_run && (r_cnt == '0);

endmodule

// File: rtl/spart_tx.sv
// SPART transmit stage: one-byte holding register in front of a shift
// register, sending 8N1 frames LSB first on a registered TX pin.
// Optional feature macro: SPART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
module spart_tx
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  spart_tx_if.slave  bus
);

  tx_state_e              r_state;
  tx_state_e              w_state_nxt;
  logic [DATA_W-1:0]      r_hold;
  logic [DATA_W-1:0]      w_hold_nxt;
  logic [DATA_W-1:0]      r_shift;
  logic [DATA_W-1:0]      w_shift_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [BIT_CNT_W-1:0]   w_bit_cnt_nxt;
  logic                   r_tbr;
  logic                   w_tbr_nxt;
  logic                   r_txd;
  logic                   w_txd_nxt;
  logic                   w_load;
  logic                   w_reload;
  logic                   w_run;
  logic                   w_bit_end;
`ifdef SPART_TX_PARITY_EN
  logic                   r_par;
  logic                   w_par_nxt;
`endif

  assign w_run = (r_state != ST_IDLE);

  spart_baud_gen u_baud (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_baud_we   (bus.baud_write_en),
    .i_baud_loc  (bus.baud_write_location),
    .i_wdata     (bus.write_line),
    .i_run       (w_run),
    .i_reload    (w_reload),
    .o_bit_end_c (w_bit_end)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, holding/shift datapath and next TX pin level
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tbr_nxt     = r_tbr;
    w_load        = 1'b0;
    w_txd_nxt     = 1'b1;
`ifdef SPART_TX_PARITY_EN
    w_par_nxt     = r_par;
`endif

    case (r_state)
      ST_IDLE: begin
        if (!r_tbr) begin
          w_load      = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
            w_bit_cnt_nxt = '0;
`ifdef SPART_TX_PARITY_EN
            w_state_nxt   = ST_PARITY;
`else
            w_state_nxt   = ST_STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
`ifdef SPART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          if (!r_tbr) begin
            // Queued byte follows with no idle gap
            w_load      = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Transfer frees the holding slot before a write is considered
    if (w_load) begin
      w_shift_nxt = r_hold;
      w_tbr_nxt   = 1'b1;
`ifdef SPART_TX_PARITY_EN
      w_par_nxt   = even_parity(r_hold);
`endif
    end

    // Write accepted only when the slot was already empty this cycle
    if (bus.transmit_write_en && r_tbr) begin
      w_hold_nxt = bus.write_line;
      w_tbr_nxt  = 1'b0;
    end

    case (w_state_nxt)
      ST_START:  w_txd_nxt = 1'b0;
      ST_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef SPART_TX_PARITY_EN
      ST_PARITY: w_txd_nxt = w_par_nxt;
`endif
      default:   w_txd_nxt = 1'b1;
    endcase
  end

  assign w_reload = w_bit_end || w_load;

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tbr     <= 1'b1;
      r_txd     <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_hold    <= w_hold_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tbr     <= w_tbr_nxt;
      r_txd     <= w_txd_nxt;
`ifdef SPART_TX_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  assign bus.tbr = r_tbr;
  assign bus.txd = r_txd;

endmodule

// File: tb/tb_spart_tx.sv
// Scoreboard bench for spart_tx: stimulus pushes the expected serial bits
// (level and length) of every accepted byte; a monitor on the TX pin pops
// and compares them bit by bit.
module tb_spart_tx;
  import spart_pkg::*;

`ifdef SPART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic val;
    int   dur;
    bit   last;
    bit   b2b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   mon_active = 1'b0;

  always #5 clk = ~clk;

  spart_tx_if bus();

  spart_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: frame = start 0, data LSB first, [even parity], stop 1.
  // The first n_a bits last d_a cycles, the rest d_b cycles.
  function automatic void push_frame(input logic [7:0] b, input int d_a,
                                     input int n_a, input int d_b, input bit b2b);
    logic bits[$];
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(logic'((b >> i) & 8'd1));
`ifdef SPART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++) begin
      e.val  = bits[i];
      e.dur  = (i < n_a) ? d_a : d_b;
      e.last = (i == bits.size() - 1);
      e.b2b  = (i == 0) ? b2b : 1'b0;
      exp_q.push_back(e);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe a byte during the current cycle; returns one cycle later
  task automatic write_byte(input logic [7:0] b);
    bus.transmit_write_en = 1'b1;
    bus.write_line        = b;
    tick();
    bus.transmit_write_en = 1'b0;
  endtask

  task automatic set_div(input logic [15:0] d);
    bus.baud_write_en       = 1'b1;
    bus.baud_write_location = 1'b0;
    bus.write_line          = d[7:0];
    tick();
    bus.baud_write_location = 1'b1;
    bus.write_line          = d[15:8];
    tick();
    bus.baud_write_en       = 1'b0;
  endtask

  // Monitor: decode the TX pin against the expected bit queue
  initial begin : monitor
    exp_t cur;
    int   cnt;
    int   idle_cnt;
    bit   bad;
    bit   junk;
    cnt = 0; idle_cnt = 0; bad = 1'b0; junk = 1'b0;
    cur = '{val: 1'b1, dur: 1, last: 1'b1, b2b: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
        idle_cnt   = 0;
        junk       = 1'b0;
      end else begin
        if (!mon_active) begin
          if (bus.txd === 1'b0 && !junk) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              junk = 1'b1;
              $display("FAIL unexpected_start: got start bit expected idle at %0t", $time);
            end else begin
              cur = exp_q.pop_front();
              if (cur.b2b) begin
                checks++;
                if (idle_cnt != 0) begin
                  errors++;
                  $display("FAIL b2b_gap: got %0d idle cycles expected 0 at %0t", idle_cnt, $time);
                end
              end
              mon_active = 1'b1;
              cnt = 0; bad = 1'b0; idle_cnt = 0;
            end
          end else if (bus.txd === 1'b1) begin
            junk = 1'b0;
            idle_cnt++;
          end
        end
        if (mon_active) begin
          if (bus.txd !== cur.val) bad = 1'b1;
          cnt++;
          if (cnt == cur.dur) begin
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL tx_bit: got wrong level within %0d-cycle bit expected %0b at %0t",
                       cur.dur, cur.val, $time);
            end
            cnt = 0; bad = 1'b0;
            if (cur.last) begin
              mon_active = 1'b0;
            end else if (exp_q.size() == 0) begin
              errors++;
              mon_active = 1'b0;
              $display("FAIL frame_underrun: got empty queue expected next bit at %0t", $time);
            end else begin
              cur = exp_q.pop_front();
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int d, p, f, w;
    logic [7:0] b1, b2;
    bus.transmit_write_en   = 1'b0;
    bus.write_line          = '0;
    bus.baud_write_en       = 1'b0;
    bus.baud_write_location = 1'b0;

    // Reset
    tick(3);
    chk("rst_txd", 32'(bus.txd), 32'd1);
    chk("rst_tbr", 32'(bus.tbr), 32'd1);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_tbr", 32'(bus.tbr), 32'd1);
    chk("post_rst_txd", 32'(bus.txd), 32'd1);
    set_div(16'd3);
    tick();
    chk("div_value", 32'(dut.u_baud.r_div), 32'd3);

    // Single byte 0xA5 at divisor 3
    f = NB * 4;
    push_frame(8'hA5, 4, NB, 4, 1'b0);
    write_byte(8'hA5);
    chk("single_tbr_c1", 32'(bus.tbr), 32'd0);
    tick();
    chk("single_tbr_c2", 32'(bus.tbr), 32'd1);
    chk("single_txd_c2", 32'(bus.txd), 32'd0);
    tick(f + 10);

    // Back-to-back: second byte queued mid-frame
    push_frame(8'h00, 4, NB, 4, 1'b0);
    write_byte(8'h00);
    tick(4);
    chk("b2b_tbr_free", 32'(bus.tbr), 32'd1);
    push_frame(8'hFF, 4, NB, 4, 1'b1);
    write_byte(8'hFF);
    chk("b2b_tbr_full", 32'(bus.tbr), 32'd0);
    tick(f - 5);
    chk("b2b_tbr_stop_end", 32'(bus.tbr), 32'd0);
    tick();
    chk("b2b_tbr_xfer", 32'(bus.tbr), 32'd1);
    chk("b2b_txd_start", 32'(bus.txd), 32'd0);
    tick(f + 10);

    // Overrun: third write while holding is full is dropped
    push_frame(8'h3C, 4, NB, 4, 1'b0);
    write_byte(8'h3C);
    tick(3);
    push_frame(8'hC3, 4, NB, 4, 1'b1);
    write_byte(8'hC3);
    tick(3);
    chk("ovr_tbr_before", 32'(bus.tbr), 32'd0);
    write_byte(8'h55);
    chk("ovr_tbr_after", 32'(bus.tbr), 32'd0);
    tick(2 * f + 10);

    // Divisor 3 -> 7 during data bit 2
    push_frame(8'h6B, 4, 4, 8, 1'b0);
    write_byte(8'h6B);
    tick(13);
    bus.baud_write_en       = 1'b1;
    bus.baud_write_location = 1'b0;
    bus.write_line          = 8'd7;
    tick();
    bus.baud_write_en       = 1'b0;
    tick((NB - 4) * 8 + 20);
    set_div(16'd3);
    tick(2);

    // Randomized bytes, divisors and optional queued second byte
    for (int it = 0; it < 12; it++) begin
      d = $urandom_range(0, 5);
      set_div(16'(d));
      tick(2);
      p  = d + 1;
      f  = NB * p;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      push_frame(b1, p, NB, p, 1'b0);
      write_byte(b1);
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom_range(2, f);
        tick(w - 1);
        chk("rnd_tbr_free", 32'(bus.tbr), 32'd1);
        push_frame(b2, p, NB, p, 1'b1);
        write_byte(b2);
      end
      tick(2 * f + 10);
    end

    // Reset during data bit 4 of 0x0F
    set_div(16'd3);
    tick(2);
    push_frame(8'h0F, 4, NB, 4, 1'b0);
    write_byte(8'h0F);
    tick(22);
    chk("rstmid_txd_bit4", 32'(bus.txd), 32'd0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rstmid_txd", 32'(bus.txd), 32'd1);
    chk("rstmid_tbr", 32'(bus.tbr), 32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(100);
    chk("rstmid_idle_txd", 32'(bus.txd), 32'd1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("monitor_idle", 32'(mon_active), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
